video_core_ctrl: RTL and testbench

Frame-synchronous controller for the chain of video cores (bar, and later cores) in the VGA video pipeline. It holds a small CPU-visible register file and drives each core's `bypass` input. New enables are applied only at a frame boundary so a frame is never split between two patterns. An optional auto-cycle mode rotates the active core every N frames for demo use.

---
 rtl/video_core_ctrl.sv | 175 +++++++++++++++++
 tb/tb_video_core_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_core_ctrl.sv
// Frame-synchronous bypass controller for the video core chain with a CPU register file.
// Define VIDEO_CTRL_AUTO_CYCLE_EN to compile in the demo auto-cycle mode.

package vga_pkg;
    typedef struct packed {
        logic        start;
        logic        line_end;
        logic [23:0] rgb;
    } vga_frame_t;
endpackage

module video_core_ctrl
    import vga_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int CYCLE_DEF = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 source_vld,
    input  vga_frame_t           source_frame,
    input  logic                 ctrl_write,
    input  logic                 ctrl_read,
    input  logic [1:0]           ctrl_addr,
    input  logic [31:0]          ctrl_wdata,
    output logic [31:0]          ctrl_rdata,
    output logic [NUM_CORES-1:0] bypass,
    output logic [15:0]          frame_cnt
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t               state_q, state_d;
    logic                 fb;
    logic                 wr_ctrl, wr_shadow, wr_cycle;
    logic                 immediate;
    logic [NUM_CORES-1:0] shadow;
    logic [NUM_CORES-1:0] bypass_d;
    logic [7:0]           cycle;
    logic                 pending;
    logic [31:0]          rdata_d;
    logic                 auto_en, auto_act;
    logic                 auto_on, auto_off, auto_step;
    logic [2:0]           active_idx, next_idx;
    logic                 unused_ok;

    assign fb        = source_vld & source_frame.start & ~stall;
    assign wr_ctrl   = ctrl_write && (ctrl_addr == 2'd0);
    assign wr_shadow = ctrl_write && (ctrl_addr == 2'd1);
    assign wr_cycle  = ctrl_write && (ctrl_addr == 2'd2);
    assign pending   = (state_q == PEND);
    assign unused_ok = ^{ctrl_wdata, source_frame};

`ifdef VIDEO_CTRL_AUTO_CYCLE_EN
    logic [7:0] auto_cnt;
    logic [7:0] period;
    logic [8:0] cnt_inc;

    assign period    = (cycle == 8'd0) ? 8'd1 : cycle;
    assign cnt_inc   = {1'b0, auto_cnt} + 9'd1;
    assign next_idx  = (active_idx == 3'(NUM_CORES - 1)) ? 3'd0 : active_idx + 3'd1;
    assign auto_on   = fb & auto_en & ~auto_act;
    assign auto_off  = fb & ~auto_en & auto_act;
    assign auto_step = fb & auto_en & auto_act & (cnt_inc >= {1'b0, period});

    // auto_en is the CPU request; auto_act follows it only on frame boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_en    <= 1'b0;
            auto_act   <= 1'b0;
            active_idx <= 3'd0;
            auto_cnt   <= 8'd0;
        end else begin
            if (wr_ctrl)
                auto_en <= ctrl_wdata[0];
            if (fb)
                auto_act <= auto_en;
            if (auto_on) begin
                active_idx <= 3'd0;
                auto_cnt   <= 8'd0;
            end else if (auto_step) begin
                active_idx <= next_idx;
                auto_cnt   <= 8'd0;
            end else if (fb & auto_en & auto_act) begin
                auto_cnt <= cnt_inc[7:0];
            end
        end
    end
`else
    assign auto_en    = 1'b0;
    assign auto_act   = 1'b0;
    assign auto_on    = 1'b0;
    assign auto_off   = 1'b0;
    assign auto_step  = 1'b0;
    assign active_idx = 3'd0;
    assign next_idx   = 3'd0;
`endif

    always_comb begin
        state_d  = state_q;
        bypass_d = bypass;
        if (auto_act || auto_on) begin
            // auto mode owns bypass; shadow writes only queue up as pending
            if (wr_shadow)
                state_d = PEND;
            if (auto_on) begin
                bypass_d = ~NUM_CORES'(1);
            end else if (auto_off) begin
                bypass_d = shadow;
                state_d  = wr_shadow ? PEND : IDLE;
            end else if (auto_step) begin
                bypass_d = ~(NUM_CORES'(1) << next_idx);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_shadow) begin
                        if (immediate)
                            bypass_d = ctrl_wdata[NUM_CORES-1:0];
                        else
                            state_d = PEND;
                    end
                end
                PEND: begin
                    if (wr_shadow && immediate) begin
                        bypass_d = ctrl_wdata[NUM_CORES-1:0];
                        state_d  = IDLE;
                    end else if (fb) begin
                        // shadow still holds the pre-write value on a colliding write
                        bypass_d = shadow;
                        state_d  = wr_shadow ? PEND : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        case (ctrl_addr)
            2'd0:    rdata_d[1:0] = {immediate, auto_en};
            2'd1:    rdata_d[NUM_CORES-1:0] = shadow;
            2'd2:    rdata_d[7:0] = cycle;
            default: rdata_d = {frame_cnt, 12'd0, active_idx, pending};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bypass     <= '1;
            shadow     <= '1;
            immediate  <= 1'b0;
            cycle      <= 8'(CYCLE_DEF);
            frame_cnt  <= 16'd0;
            ctrl_rdata <= 32'd0;
        end else begin
            state_q <= state_d;
            bypass  <= bypass_d;
            if (wr_ctrl)
                immediate <= ctrl_wdata[1];
            if (wr_shadow)
                shadow <= ctrl_wdata[NUM_CORES-1:0];
            if (wr_cycle)
                cycle <= ctrl_wdata[7:0];
            if (fb)
                frame_cnt <= frame_cnt + 16'd1;
            if (ctrl_read)
                ctrl_rdata <= rdata_d;
        end
    end

endmodule

// File: tb/tb_video_core_ctrl.sv
// Directed bench for video_core_ctrl: frame-aligned updates, immediate mode, collisions, stall, reset, auto-cycle.

module tb_video_core_ctrl;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        source_vld;
    vga_frame_t  source_frame;
    logic        ctrl_write;
    logic        ctrl_read;
    logic [1:0]  ctrl_addr;
    logic [31:0] ctrl_wdata;
    logic [31:0] ctrl_rdata;
    logic [3:0]  bypass;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] rv;

    video_core_ctrl #(.NUM_CORES(4), .CYCLE_DEF(60)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .source_vld   (source_vld),
        .source_frame (source_frame),
        .ctrl_write   (ctrl_write),
        .ctrl_read    (ctrl_read),
        .ctrl_addr    (ctrl_addr),
        .ctrl_wdata   (ctrl_wdata),
        .ctrl_rdata   (ctrl_rdata),
        .bypass       (bypass),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        ctrl_write = 1'b1;
        ctrl_addr  = a;
        ctrl_wdata = d;
        tick();
        ctrl_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        ctrl_read = 1'b1;
        ctrl_addr = a;
        tick();
        ctrl_read = 1'b0;
        d = ctrl_rdata;
    endtask

    task automatic frame();
        source_frame.start = 1'b1;
        tick();
        source_frame.start = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        source_vld   = 1'b1;
        source_frame = '0;
        ctrl_write   = 1'b0;
        ctrl_read    = 1'b0;
        ctrl_addr    = 2'd0;
        ctrl_wdata   = 32'd0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("rst_bypass", 32'(bypass), 32'hF);
        check("rst_fcnt", 32'(frame_cnt), 32'd0);
        check("rst_rdata", ctrl_rdata, 32'd0);
        rd(2'd3, rv);
        check("rst_status", rv, 32'd0);

        // frame-aligned update
        wr(2'd1, 32'hE);
        check("pend_bypass_hold", 32'(bypass), 32'hF);
        rd(2'd3, rv);
        check("pend_status", rv, 32'h0000_0001);
        check("pend_bypass_hold2", 32'(bypass), 32'hF);
        frame();
        check("fb_bypass", 32'(bypass), 32'hE);
        check("fb_fcnt", 32'(frame_cnt), 32'd1);
        rd(2'd3, rv);
        check("fb_status", rv, 32'h0001_0000);
        rd(2'd1, rv);
        check("shadow_rd", rv, 32'hE);

        // immediate mode
        wr(2'd0, 32'h2);
        rd(2'd0, rv);
        check("ctrl_rd_imm", rv, 32'h2);
        wr(2'd1, 32'h5);
        check("imm_bypass", 32'(bypass), 32'h5);
        rd(2'd3, rv);
        check("imm_status", rv, 32'h0001_0000);
        wr(2'd0, 32'h0);

        // collision while pending: old shadow applied, new stays pending
        wr(2'd1, 32'hE);
        check("col_pre_bypass", 32'(bypass), 32'h5);
        ctrl_write = 1'b1;
        ctrl_addr  = 2'd1;
        ctrl_wdata = 32'hD;
        source_frame.start = 1'b1;
        tick();
        ctrl_write = 1'b0;
        source_frame.start = 1'b0;
        check("col_bypass", 32'(bypass), 32'hE);
        rd(2'd3, rv);
        check("col_status", rv, 32'h0002_0001);
        frame();
        check("col_next_bypass", 32'(bypass), 32'hD);
        rd(2'd3, rv);
        check("col_next_status", rv, 32'h0003_0000);

        // collision while idle: write goes pending, applied next frame
        ctrl_write = 1'b1;
        ctrl_addr  = 2'd1;
        ctrl_wdata = 32'h3;
        source_frame.start = 1'b1;
        tick();
        ctrl_write = 1'b0;
        source_frame.start = 1'b0;
        check("idlecol_bypass", 32'(bypass), 32'hD);
        rd(2'd3, rv);
        check("idlecol_status", rv, 32'h0004_0001);
        frame();
        check("idlecol_next_bypass", 32'(bypass), 32'h3);

        // stall across start beat
        wr(2'd1, 32'h8);
        stall = 1'b1;
        source_frame.start = 1'b1;
        tick();
        tick();
        tick();
        check("stall_fcnt", 32'(frame_cnt), 32'd5);
        check("stall_bypass", 32'(bypass), 32'h3);
        stall = 1'b0;
        tick();
        source_frame.start = 1'b0;
        check("unstall_fcnt", 32'(frame_cnt), 32'd6);
        check("unstall_bypass", 32'(bypass), 32'h8);

        // start without valid is not a boundary
        source_vld = 1'b0;
        frame();
        source_vld = 1'b1;
        check("novld_fcnt", 32'(frame_cnt), 32'd6);

        // read and write same address in one cycle returns old value
        ctrl_write = 1'b1;
        ctrl_read  = 1'b1;
        ctrl_addr  = 2'd2;
        ctrl_wdata = 32'h7;
        tick();
        ctrl_write = 1'b0;
        ctrl_read  = 1'b0;
        check("rw_old", ctrl_rdata, 32'h3C);
        rd(2'd2, rv);
        check("rw_new", rv, 32'h7);

        // STATUS is read-only
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, rv);
        check("status_ro", rv, 32'h0006_0000);

        // reset mid-frame drops pending update
        wr(2'd1, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_bypass", 32'(bypass), 32'hF);
        check("rst2_fcnt", 32'(frame_cnt), 32'd0);
        check("rst2_rdata", ctrl_rdata, 32'd0);
        frame();
        check("rst2_fb_bypass", 32'(bypass), 32'hF);
        rd(2'd1, rv);
        check("rst2_shadow", rv, 32'hF);
        rd(2'd2, rv);
        check("rst2_cycle", rv, 32'h3C);

        rst = 1'b1;
        tick();
        rst = 1'b0;

`ifdef VIDEO_CTRL_AUTO_CYCLE_EN
        // auto cycle every 2 frames
        wr(2'd2, 32'h2);
        wr(2'd0, 32'h1);
        rd(2'd0, rv);
        check("auto_ctrl_rd", rv, 32'h1);
        check("auto_wait_fb", 32'(bypass), 32'hF);
        frame();
        check("auto_f1", 32'(bypass), 32'hE);
        frame();
        check("auto_f2", 32'(bypass), 32'hE);
        frame();
        check("auto_f3", 32'(bypass), 32'hD);
        rd(2'd3, rv);
        check("auto_status", rv, 32'h0003_0002);
        frame();
        frame();
        check("auto_f5", 32'(bypass), 32'hB);
        frame();
        frame();
        check("auto_f7", 32'(bypass), 32'h7);
        frame();
        check("auto_f8", 32'(bypass), 32'h7);
        frame();
        check("auto_f9_wrap", 32'(bypass), 32'hE);
        wr(2'd1, 32'h6);
        wr(2'd0, 32'h0);
        check("auto_off_wait", 32'(bypass), 32'hE);
        frame();
        check("auto_off_bypass", 32'(bypass), 32'h6);
        rd(2'd3, rv);
        check("auto_off_status", rv, 32'h000A_0000);
`else
        // without auto support CTRL bit0 is not writable
        wr(2'd0, 32'h1);
        rd(2'd0, rv);
        check("noauto_ctrl_rd", rv, 32'h0);
        frame();
        frame();
        check("noauto_bypass", 32'(bypass), 32'hF);
        rd(2'd3, rv);
        check("noauto_status", rv, 32'h0002_0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
